// File: rtl/enum_code_tx.sv
// Burst generator for enum_t codes (ONE -> TWO -> THREE -> ONE ...) on a
// valid/ready stream, with early abort and per-burst beat accounting.
module enum_code_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_code,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  typedef enum logic [WIDTH-1:0] {
    ONE   = WIDTH'(0),
    TWO   = WIDTH'(1),
    THREE = WIDTH'(2)
  } enum_t;

  state_t           state, state_nx;
  enum_t            code, code_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ab_r, ab_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code      <= ONE;
      remaining <= '0;
      cnt       <= '0;
      ab_r      <= 1'b0;
    end else begin
      state     <= state_nx;
      code      <= code_nx;
      remaining <= remaining_nx;
      cnt       <= cnt_nx;
      ab_r      <= ab_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    code_nx      = code;
    remaining_nx = remaining;
    cnt_nx       = cnt;
    ab_nx        = ab_r;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nx  = '0;
          ab_nx   = 1'b0;
          code_nx = ONE;
          if (burst_len != '0) begin
            remaining_nx = burst_len;
            state_nx     = SEND;
          end else begin
            state_nx = DONE;
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          cnt_nx       = cnt + CNT_W'(1);
          remaining_nx = remaining - CNT_W'(1);
          case (code)
            ONE:     code_nx = TWO;
            TWO:     code_nx = THREE;
            default: code_nx = ONE;
          endcase
          // The final transfer wins over a coincident abort.
          if (remaining == CNT_W'(1)) begin
            state_nx = DONE;
          end else if (abort) begin
            state_nx = DONE;
            ab_nx    = 1'b1;
          end
        end else if (abort) begin
          state_nx = DONE;
          ab_nx    = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (state == SEND);
  assign out_code  = code;
  assign out_last  = (state == SEND) && (remaining == CNT_W'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign aborted   = ab_r;
  assign beat_cnt  = cnt;

endmodule

// File: doc/enum_code_tx.md
Name: enum_code_tx

Overview:
- Transmit-side counterpart of the enum_t consumer blocks.
- Generates a burst of enum_t codes on a valid/ready stream. Codes cycle ONE -> TWO -> THREE -> ONE ...
- Lets the enum/typedef-carrying sink modules be driven and checked in-system with a deterministic, back-pressurable code sequence.

Parameters:
- WIDTH, 8, width of enum_t code (ONE=8'h00, TWO=8'h01, THREE=8'h02)
- CNT_W, 8, width of burst length and beat counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a burst; sampled only in IDLE
- burst_len  input  CNT_W  beats in burst; latched with start
- abort  input  1  terminate an active burst early
- out_valid  output  1  out_code valid
- out_ready  input  1  sink accepts beat when out_valid & out_ready
- out_code  output  WIDTH  enum_t code (wiretype enum_t)
- out_last  output  1  current beat is final beat of burst
- busy  output  1  high in SEND and DONE
- done  output  1  one-cycle pulse at burst end
- aborted  output  1  valid with done; burst ended by abort
- beat_cnt  output  CNT_W  beats accepted in current/last burst

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (async, immediate on rst_n low):
  - state=IDLE.
  - out_valid=0, out_code=ONE, out_last=0, busy=0, done=0, aborted=0, beat_cnt=0.
  - Reset mid-burst discards the burst. No done pulse is produced.
- FSM states:
  - IDLE: out_valid=0.
    - start=1 and burst_len!=0: latch remaining=burst_len, set beat_cnt=0, go to SEND.
    - start=1 and burst_len==0: go to DONE with aborted=0. No beats are sent.
  - SEND: out_valid=1 from the first cycle after start is accepted (latency 1). The first code is ONE.
  - DONE: exactly one cycle. done=1, out_valid=0, then return to IDLE.
- Handshake:
  - A beat transfers on a cycle with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_code and out_last hold stable.
  - out_valid never drops without a transfer, except on abort.
- Per transfer:
  - beat_cnt += 1.
  - remaining -= 1.
  - Code advances ONE -> TWO -> THREE -> ONE. THREE wraps to ONE.
- out_last=1 exactly when remaining==1 in SEND.
- The transfer with out_last=1 moves the FSM to DONE with aborted=0.
- Abort:
  - abort=1 in SEND with no transfer that cycle: go to DONE with aborted=1. out_valid is 0 the next cycle.
  - abort coincident with a non-final transfer: the beat counts, then DONE with aborted=1.
  - abort coincident with the final transfer: normal completion, aborted=0.
  - abort in IDLE or DONE: ignored.
- start while busy: ignored, not queued.
- start in the same cycle as DONE: ignored. A new start is accepted in IDLE at the earliest, so bursts are back-to-back with at least one idle cycle.
- aborted holds its value until the next accepted start, which clears it.
- beat_cnt holds after DONE until the next accepted start.
- Width rules:
  - remaining and beat_cnt are CNT_W unsigned.
  - burst_len=2^CNT_W-1 is the maximum burst. beat_cnt does not wrap within a burst.
- out_code uses only enum values ONE/TWO/THREE. The upper WIDTH-2 bits are always 0.

Test Plan:
- Reset, then start with burst_len=5 and out_ready=1:
  - codes 00,01,02,00,01 on 5 consecutive cycles starting one cycle after start.
  - out_last on the 5th beat.
  - done pulse with aborted=0 next cycle, beat_cnt=5.
- burst_len=3, out_ready toggled 0,1,0,0,1,1:
  - out_code held stable while stalled.
  - exactly 3 transfers (00,01,02).
  - out_valid never drops mid-burst.
- burst_len=10, abort asserted after 4 transfers with out_ready=0:
  - out_valid low next cycle.
  - done=1, aborted=1, beat_cnt=4.
- burst_len=2, abort coincident with the 2nd (final) transfer -> done=1, aborted=0, beat_cnt=2.
- start with burst_len=0 -> no out_valid, done pulse one cycle later, beat_cnt=0.
- Start with burst_len=8, start re-pulsed mid-burst, rst_n pulsed low after 3 beats:
  - the mid-burst start is ignored.
  - all outputs go to reset values immediately on rst_n low, with no done pulse.
  - a fresh start then restarts at code 00.
